// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between
// instruction fetch (I) and data (D) requesters.
module mem_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] i_a,
  input  logic        i_access,
  input  logic        i_write,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_st_data,
  output logic        i_ready,
  output logic [31:0] i_data,
  input  logic [31:0] d_a,
  input  logic        d_access,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_st_data,
  output logic        d_ready,
  output logic [31:0] d_data,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;
  logic   last_d;
  logic   gnt_i;
  logic   gnt_d;
  logic   busy;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  // Grant decision and next state; D wins a tie unless it won last.
  always_comb begin
    state_nx = state;
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_d = d_access && (!i_access || !last_d);
        gnt_i = i_access && !gnt_d;
        if (gnt_d)
          state_nx = BUSY_D;
        else if (gnt_i)
          state_nx = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready)
          state_nx = DRAIN;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nx;
      if (gnt_i || gnt_d)
        last_d <= gnt_d;
    end
  end

  // Capture the winner's request; frozen until the next grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_a       <= '0;
      mem_write   <= 1'b0;
      mem_size    <= '0;
      mem_sel     <= '0;
      mem_st_data <= '0;
    end else if (gnt_d) begin
      mem_a       <= d_a;
      mem_write   <= d_write;
      mem_size    <= d_size;
      mem_sel     <= d_sel;
      mem_st_data <= d_st_data;
    end else if (gnt_i) begin
      mem_a       <= i_a;
      mem_write   <= i_write;
      mem_size    <= i_size;
      mem_sel     <= i_sel;
      mem_st_data <= i_st_data;
    end
  end

  // Request flag: raised on grant, dropped on completion.
  always_ff @(posedge clk) begin
    if (!resetn)
      mem_access <= 1'b0;
    else if (gnt_i || gnt_d)
      mem_access <= 1'b1;
    else if (busy && mem_ready)
      mem_access <= 1'b0;
  end

  // Completion is steered to the granted side only; reset suppresses it.
  always_comb begin
    i_ready = resetn && (state == BUSY_I) && mem_ready;
    d_ready = resetn && (state == BUSY_D) && mem_ready;
    i_data  = i_ready ? mem_data : '0;
    d_data  = d_ready ? mem_data : '0;
  end

endmodule
